// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO family.
//   DATA_BUS_SIZE     : default bus word width
//   clog2()           : ceiling log2 helper for sizing counters/pointers
//   FIFO_CHECK_THRESH : elaboration-time guard for almost-full/almost-empty thresholds;
//                       expands to a generate-if that raises $error on illegal values.
`ifndef FIFO_PKG_SV
`define FIFO_PKG_SV

`define FIFO_CHECK_THRESH(AF, AE, DEPTH) \
    if (((AF) < 1) || ((AF) > (DEPTH)) || ((AE) < 0) || ((AE) > ((DEPTH) - 1))) begin : g_bad_thresh \
        $error("fifo: AF_THRESH must be 1..DEPTH and AE_THRESH must be 0..DEPTH-1"); \
    end

package fifo_pkg;

    localparam int DATA_BUS_SIZE = 32;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >>> 1;
        end
        return result;
    endfunction

endpackage

`endif

// File: rtl/fifo_mem_2p.sv
// Storage array for the FIFO: one synchronous write port, one asynchronous read port.
// Contents are never reset; the owning FIFO guarantees stale words are never observable.
//   clk   in  : clock
//   we    in  : write enable
//   waddr in  : write address
//   wdata in  : write data
//   raddr in  : read address
//   rdata out : read data (combinational from raddr)
module fifo_mem_2p
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_BUS_SIZE,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Parametrised single-clock FIFO with fill count, programmable almost-full/almost-empty
// flags, selectable registered or first-word-fall-through read, synchronous flush and
// sticky overflow/underflow flags.
//   clk, rst (sync, active high), flush (clears pointers/count), clr_err (clears errors)
//   wr/data_in           : write request and data
//   rd/data_out          : read request (pop acknowledge in FWFT mode) and data
//   full, empty, almost_full, almost_empty, count : status from registered pointers
//   overflow, underflow  : sticky error flags
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_BUS_SIZE,
    parameter int ADDR_WIDTH = 3,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = 7,
    parameter int AE_THRESH  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  clr_err,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] AF_C    = PTR_W'(AF_THRESH);
    localparam logic [PTR_W-1:0] AE_C    = PTR_W'(AE_THRESH);
    localparam logic [PTR_W-1:0] ONE_C   = PTR_W'(1);

    `FIFO_CHECK_THRESH(AF_THRESH, AE_THRESH, DEPTH)

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic [PTR_W-1:0]      count_w;
    logic                  rd_acc, wr_acc, mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // The extra MSB on each pointer distinguishes full from empty, so the modular
    // difference is the exact fill level 0..DEPTH.
    assign count_w      = wr_ptr_q - rd_ptr_q;
    assign count        = count_w;
    assign full         = (count_w == DEPTH_C);
    assign empty        = (count_w == '0);
    assign almost_full  = (count_w >= AF_C);
    assign almost_empty = (count_w <= AE_C);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    always_comb begin
        rd_acc      = rd & ~empty;
        // A write into a full FIFO is fine when a read frees the slot in the same cycle.
        wr_acc      = wr & (~full | rd_acc);
        mem_we      = wr_acc & ~flush;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (flush) begin
            // Requests coinciding with a flush are dropped silently, never flagged.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + ONE_C;
            if (rd_acc) rd_ptr_d = rd_ptr_q + ONE_C;
            // Set after the clear so a new error wins over clr_err.
            if (wr & ~wr_acc) overflow_d = 1'b1;
            if (rd & ~rd_acc) underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem_2p #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .waddr(wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata(data_in),
        .raddr(rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata(mem_rdata)
    );

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented directly; forced to zero when nothing is stored.
            assign data_out = empty ? '0 : mem_rdata;
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

            always_comb begin
                data_out_d = data_out_q;
                if (flush) begin
                    data_out_d = '0;
                end else if (rd_acc) begin
                    data_out_d = mem_rdata;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_out_q <= '0;
                end else begin
                    data_out_q <= data_out_d;
                end
            end

            assign data_out = data_out_q;
        end
    endgenerate

endmodule
